timer_ctrl: RTL

Register-mapped controller that configures and sequences the 8-bit up/down counter of the timer module. It holds the start value and control bits, generates the prescaled clk_ena tick and the one-cycle load strobe, and captures the counter's overflow/underflow outputs into sticky, write-1-to-clear status flags. It drives a maskable interrupt. It sits between the host APB-style bus and the counter.

---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_prescaler.sv | 46 ++++
 rtl/timer_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: register map, bit positions
// and the prescaler terminal-count helper.
package timer_pkg;

   typedef enum logic [1:0] {
      REG_TDR  = 2'd0,
      REG_TCR  = 2'd1,
      REG_TSR  = 2'd2,
      REG_TIER = 2'd3
   } reg_addr_e;

   // TCR fields
   localparam int TCR_LOAD    = 7;
   localparam int TCR_UD      = 5;
   localparam int TCR_EN      = 4;
   localparam int TCR_CKS_LSB = 0;

   // TSR fields
   localparam int TSR_OVF = 0;
   localparam int TSR_UDF = 1;

   // TIER fields
   localparam int TIER_OVFIE = 0;
   localparam int TIER_UDFIE = 1;

   // Last prescaler count before a tick: a clock select of cks divides by 2^(cks+1).
   function automatic int psc_last(input int cks);
      return (2 << cks) - 1;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler producing a one-cycle count tick every 2^(cks+1) clocks.
// Held at zero while disabled; clr restarts the division from zero.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PSC_W = 4,
   parameter int CKS_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [CKS_W-1:0] cks,
   output logic             tick
);

   logic [PSC_W-1:0] cnt_q;
   logic [PSC_W-1:0] cnt_d;
   logic [PSC_W-1:0] last;
   logic             at_last;

   // Terminal count compare and next count value
   always_comb begin
      last    = PSC_W'(psc_last(int'(cks)));
      at_last = (cnt_q == last);
      cnt_d   = cnt_q;
      if (clr || !en) begin
         cnt_d = '0;
      end else if (at_last) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PSC_W'(1);
      end
      tick = en && at_last;
   end

   // Prescaler count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// Register-mapped controller for the 8-bit up/down timer counter: holds the
// start value and control bits, sequences the load strobe and prescaled tick,
// and latches counter overflow/underflow into sticky W1C status with a
// maskable level interrupt.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int PSC_W = 4,
   parameter int CKS_W = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [1:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   input  logic       ovf_in,
   input  logic       udf_in,
   output logic       cnt_enable,
   output logic       cnt_up_down,
   output logic       cnt_load,
   output logic       cnt_clk_ena,
   output logic [7:0] cnt_start,
   output logic       irq
);

   logic [7:0]       tdr_q,     tdr_d;
   logic             ud_q,      ud_d;
   logic             en_q,      en_d;
   logic [CKS_W-1:0] cks_q,     cks_d;
   logic             load_q,    load_d;
   logic             ovf_q,     ovf_d;
   logic             udf_q,     udf_d;
   logic             ovfie_q,   ovfie_d;
   logic             udfie_q,   udfie_d;
   logic             ovf_in_q,  ovf_in_d;
   logic             udf_in_q,  udf_in_d;
   logic             irq_q,     irq_d;

   logic             wr_en;
   logic             wr_tdr;
   logic             wr_tcr;
   logic             wr_tsr;
   logic             wr_tier;
   logic             rd_en;
   logic             psc_clr;
   logic             ovf_rise;
   logic             udf_rise;
   logic             tick;

   // Bus write decode, prescaler restart and counter-flag edge detection
   always_comb begin
      wr_en    = psel & penable & pwrite;
      rd_en    = psel & ~pwrite;
      wr_tdr   = wr_en && (paddr == REG_TDR);
      wr_tcr   = wr_en && (paddr == REG_TCR);
      wr_tsr   = wr_en && (paddr == REG_TSR);
      wr_tier  = wr_en && (paddr == REG_TIER);
      // A new clock select or a load must start the division from a clean phase.
      psc_clr  = wr_tcr && (pwdata[TCR_LOAD] ||
                            (pwdata[TCR_CKS_LSB +: CKS_W] != cks_q));
      // The counter holds its flags as levels between ticks; only a fresh rise is an event.
      ovf_rise = ovf_in & ~ovf_in_q;
      udf_rise = udf_in & ~udf_in_q;
   end

   // Next-state for control, status and interrupt registers
   always_comb begin
      tdr_d    = tdr_q;
      ud_d     = ud_q;
      en_d     = en_q;
      cks_d    = cks_q;
      ovfie_d  = ovfie_q;
      udfie_d  = udfie_q;
      ovf_in_d = ovf_in;
      udf_in_d = udf_in;

      if (wr_tdr) begin
         tdr_d = pwdata;
      end
      if (wr_tcr) begin
         ud_d  = pwdata[TCR_UD];
         en_d  = pwdata[TCR_EN];
         cks_d = pwdata[TCR_CKS_LSB +: CKS_W];
      end
      if (wr_tier) begin
         ovfie_d = pwdata[TIER_OVFIE];
         udfie_d = pwdata[TIER_UDFIE];
      end

      // LOAD is a command bit, never stored: it only produces the one-cycle strobe.
      load_d = wr_tcr & pwdata[TCR_LOAD];

      // A set event on the same edge as a write-1-to-clear keeps the flag set.
      ovf_d = ovf_rise | (ovf_q & ~(wr_tsr & pwdata[TSR_OVF]));
      udf_d = udf_rise | (udf_q & ~(wr_tsr & pwdata[TSR_UDF]));

      irq_d = (ovf_q & ovfie_q) | (udf_q & udfie_q);
   end

   // Register state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdr_q    <= '0;
         ud_q     <= 1'b0;
         en_q     <= 1'b0;
         cks_q    <= '0;
         load_q   <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         ovfie_q  <= 1'b0;
         udfie_q  <= 1'b0;
         ovf_in_q <= 1'b0;
         udf_in_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         tdr_q    <= tdr_d;
         ud_q     <= ud_d;
         en_q     <= en_d;
         cks_q    <= cks_d;
         load_q   <= load_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         ovfie_q  <= ovfie_d;
         udfie_q  <= udfie_d;
         ovf_in_q <= ovf_in_d;
         udf_in_q <= udf_in_d;
         irq_q    <= irq_d;
      end
   end

   // Combinational read mux; only driven during a read, zero otherwise
   always_comb begin
      prdata = '0;
      if (rd_en) begin
         case (paddr)
            REG_TDR: begin
               prdata = tdr_q;
            end
            REG_TCR: begin
               prdata[TCR_UD]                  = ud_q;
               prdata[TCR_EN]                  = en_q;
               prdata[TCR_CKS_LSB +: CKS_W]    = cks_q;
            end
            REG_TSR: begin
               prdata[TSR_OVF] = ovf_q;
               prdata[TSR_UDF] = udf_q;
            end
            REG_TIER: begin
               prdata[TIER_OVFIE] = ovfie_q;
               prdata[TIER_UDFIE] = udfie_q;
            end
            default: begin
               prdata = '0;
            end
         endcase
      end
   end

   timer_prescaler #(
      .PSC_W (PSC_W),
      .CKS_W (CKS_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_q),
      .clr   (psc_clr),
      .cks   (cks_q),
      .tick  (tick)
   );

   assign pready      = 1'b1;
   assign cnt_enable  = en_q;
   assign cnt_up_down = ud_q;
   assign cnt_load    = load_q;
   assign cnt_clk_ena = tick;
   assign cnt_start   = tdr_q;
   assign irq         = irq_q;

endmodule
